inv_line_rx: RTL and testbench
==============================

Name: inv_line_rx

Overview:
- Serial receiver for the far end of the common-emitter line driver; samples the driver's collector node (OUT), which is a logically inverted copy of the transmitted NRZ stream.
- Functions: synchronizes, optionally re-inverts, oversamples, majority-votes and deframes 8N1-style frames into parallel words.
- Output: a valid/ready handshake toward the digital core.

Parameters:
- OVERSAMPLE, 16: clock cycles per bit; even, ≥8.
- DATA_W, 8: data bits per frame, LSB first.
- SYNC_STAGES, 2: flip-flops in the input synchronizer; ≥2.
- LINE_INV, 1: 1 = line level is inverted (idle low), so re-invert after the synchronizer; 0 = pass-through.

Ports:
- clk  in  1  single block clock.
- rst  in  1  asynchronous, active-high reset.
- line_i  in  1  raw line from the amplifier output node; asynchronous to clk.
- data_o  out  DATA_W  received word; stable while valid_o=1.
- valid_o  out  1  word available.
- ready_i  in  1  consumer accepts; transfer occurs when valid_o & ready_i.
- busy_o  out  1  frame reception in progress (state ≠ IDLE/ARM).
- frame_err_o  out  1  one-cycle pulse: stop bit sampled as 0.
- overrun_o  out  1  one-cycle pulse: frame completed while the previous word was still held.
- parity_err_o  out  1  one-cycle pulse on parity mismatch; constant 0 when the optional feature is compiled out.

Behaviour:
- Reset values: data_o=0, valid_o=0, busy_o=0, all error pulses 0, state=ARM, counters=0.
- Input path:
  - line_i passes through SYNC_STAGES flops, then the LINE_INV inversion.
  - The result is the logical line `rx`, where idle = 1.
- ARM: wait until rx=1 for one full OVERSAMPLE period. This prevents a false start after reset mid-frame or after a break. Then go to IDLE.
- IDLE:
  - rx 1→0 edge starts a frame: go to START, phase counter = 0.
- Phase counter:
  - Width $clog2(OVERSAMPLE); wraps at OVERSAMPLE-1.
  - Bit decision = majority of rx at phases OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The decision is registered at phase OVERSAMPLE/2+1.
- START:
  - Decided 1 → false start, return to IDLE with no error.
  - Decided 0 → at wrap, go to DATA with bit counter = 0.
- DATA:
  - Shift the decided bit into the shift register MSB, so the word ends LSB-first.
  - Bit counter width is $clog2(DATA_W+1).
  - After DATA_W bits, go to PARITY if enabled, else STOP.
- STOP: at the decision point:
  - Decided 0:
    - Pulse frame_err_o; discard the word.
    - Go to ARM, so the line must return to idle; a break holds here.
  - Decided 1, valid_o=0 or (valid_o & ready_i) in the same cycle:
    - Load data_o and set valid_o on the next edge.
    - Latency from stop decision to valid_o: 1 cycle.
  - Decided 1, valid_o=1 and ready_i=0:
    - Keep the old data_o; pulse overrun_o; drop the new word.
  - Then go to IDLE immediately at the decision point, not at the bit end. This permits back-to-back frames with a half-bit of slack.
- Handshake:
  - valid_o clears on the cycle after valid_o & ready_i unless a new word loads in that same cycle.
  - The load takes priority, so valid_o stays 1.
  - data_o never changes while valid_o=1 and ready_i=0.
- rst at any time aborts the frame with no error pulse and returns to ARM.

Optional Feature:
- Macro INV_LINE_RX_PARITY_EN.
- Defined:
  - An even-parity bit follows the data bits (PARITY state, same majority sampling).
  - On mismatch, pulse parity_err_o coincident with the stop decision; the word is still delivered.
  - A mismatch and a frame error on the same frame pulse both.
- Undefined:
  - No PARITY state; frame = start + DATA_W + stop.
  - parity_err_o is tied to 0.

Decomposition:
- Package inv_line_rx_pkg:
  - State enum: ARM, IDLE, START, DATA, PARITY, STOP.
  - Majority-sample phase offset constants.
  - Helper function for the majority of 3.
- One sub-module, inv_line_rx_sync: the SYNC_STAGES synchronizer plus LINE_INV inversion; reset to the logical idle value 1.

Test Plan:
- LINE_INV=1, OVERSAMPLE=16: drive inverted frame for 0xA5 with ready_i=1 → data_o=0xA5, valid_o for 1 cycle, no error pulses.
- Start pulse only 6 cycles wide → no valid_o, no error, back to IDLE, busy_o drops.
- Stop bit held low (line high, since inverted) → frame_err_o pulse; no valid_o until the line idles ≥16 cycles and a new frame for 0x3C arrives → 0x3C delivered.
- ready_i=0: send 0x11 then 0x22 → data_o stays 0x11, overrun_o pulse at the second stop; raise ready_i → valid_o clears.
- Single 1-cycle glitch inside each data bit at phase 8 → majority vote still yields 0x5A.
- rst asserted mid-DATA of 0xFF, released while the line is still active → no output until 16 idle cycles; next frame 0x81 received correctly; with INV_LINE_RX_PARITY_EN, a wrong parity on 0x81 → parity_err_o pulse and word delivered.

Source files
------------

// File: rtl/inv_line_rx_pkg.sv
// Shared types and helpers for the inverted-line serial receiver.
package inv_line_rx_pkg;

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Majority samples are taken at centre-MAJ_LEAD, centre, centre+MAJ_LAG
  localparam int unsigned MAJ_LEAD = 1;
  localparam int unsigned MAJ_LAG  = 1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/inv_line_rx_sync.sv
// Input synchronizer for the asynchronous line, followed by optional
// re-inversion so the output is the logical line (idle = 1).
module inv_line_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LINE_INV    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic rx
);

  localparam logic INV      = (LINE_INV != 0);
  // Raw line level that corresponds to a logical idle of 1
  localparam logic RAW_IDLE = ~INV;

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the raw line through the synchronizer chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {SYNC_STAGES{RAW_IDLE}};
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
  end

  assign rx = sync_q[SYNC_STAGES-1] ^ INV;

endmodule

// File: rtl/inv_line_rx.sv
// Oversampling 8N1-style receiver for an inverted NRZ line.
// Optional even parity bit enabled by defining INV_LINE_RX_PARITY_EN.
import inv_line_rx_pkg::*;

module inv_line_rx #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LINE_INV    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              frame_err_o,
  output logic              overrun_o,
  output logic              parity_err_o
);

  localparam int unsigned PH_W = $clog2(OVERSAMPLE);
  localparam int unsigned BC_W = $clog2(DATA_W + 1);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0] PH_S0   = PH_W'(OVERSAMPLE / 2 - MAJ_LEAD);
  localparam logic [PH_W-1:0] PH_S1   = PH_W'(OVERSAMPLE / 2);
  localparam logic [PH_W-1:0] PH_DEC  = PH_W'(OVERSAMPLE / 2 + MAJ_LAG);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W);

  logic              rx;
  logic              rx_d;
  state_t            state;
  logic [PH_W-1:0]   phase;
  logic [BC_W-1:0]   bit_cnt;
  logic              samp0;
  logic              samp1;
  logic [DATA_W-1:0] shreg;
  logic              bit_dec;
  logic              at_dec;
  logic              at_wrap;
  logic              in_frame;
`ifdef INV_LINE_RX_PARITY_EN
  logic              par_bit;
  logic              parity_err_q;
`endif

  inv_line_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .LINE_INV   (LINE_INV)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .line_i(line_i),
    .rx    (rx)
  );

  // Majority of the two stored samples and the live third sample
  always_comb begin
    bit_dec  = maj3(samp0, samp1, rx);
    at_dec   = (phase == PH_DEC);
    at_wrap  = (phase == PH_LAST);
    in_frame = (state == START) || (state == DATA) ||
               (state == PARITY) || (state == STOP);
  end

  // Receive FSM, bit timing, deframing and output handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ARM;
      rx_d         <= 1'b1;
      phase        <= '0;
      bit_cnt      <= '0;
      samp0        <= 1'b0;
      samp1        <= 1'b0;
      shreg        <= '0;
      data_o       <= '0;
      valid_o      <= 1'b0;
      busy_o       <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
`ifdef INV_LINE_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_d        <= rx;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef INV_LINE_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      // Consumer handshake; a load in STOP below overrides this clear
      if (valid_o && ready_i) valid_o <= 1'b0;

      if (in_frame) begin
        phase <= at_wrap ? '0 : phase + 1'b1;
        if (phase == PH_S0) samp0 <= rx;
        if (phase == PH_S1) samp1 <= rx;
      end

      case (state)
        ARM: begin
          // phase counts consecutive idle cycles here
          if (!rx) begin
            phase <= '0;
          end else if (phase == PH_LAST) begin
            phase <= '0;
            state <= IDLE;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        IDLE: begin
          if (!rx && rx_d) begin
            state  <= START;
            phase  <= '0;
            busy_o <= 1'b1;
          end
        end
        START: begin
          if (at_dec && bit_dec) begin
            state  <= IDLE;
            phase  <= '0;
            busy_o <= 1'b0;
          end else if (at_wrap) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (at_dec) begin
            shreg   <= {bit_dec, shreg[DATA_W-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (at_wrap && (bit_cnt == BC_LAST)) begin
`ifdef INV_LINE_RX_PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end
        end
`ifdef INV_LINE_RX_PARITY_EN
        PARITY: begin
          if (at_dec)  par_bit <= bit_dec;
          if (at_wrap) state   <= STOP;
        end
`endif
        STOP: begin
          // Leave at the decision point so the next start edge is not missed
          if (at_dec) begin
            busy_o <= 1'b0;
            phase  <= '0;
`ifdef INV_LINE_RX_PARITY_EN
            parity_err_q <= (par_bit != ^shreg);
`endif
            if (!bit_dec) begin
              frame_err_o <= 1'b1;
              state       <= ARM;
            end else begin
              state <= IDLE;
              if (!valid_o || ready_i) begin
                data_o  <= shreg;
                valid_o <= 1'b1;
              end else begin
                overrun_o <= 1'b1;
              end
            end
          end
        end
        default: begin
          state  <= ARM;
          phase  <= '0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef INV_LINE_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_inv_line_rx.sv
// Directed bench for inv_line_rx with LINE_INV=1, OVERSAMPLE=16, DATA_W=8.
module tb_inv_line_rx;

  localparam int unsigned OS = 16;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          line_i;
  logic          ready_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          busy_o;
  logic          frame_err_o;
  logic          overrun_o;
  logic          parity_err_o;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Event counts gathered by the monitor (sole writer)
  int unsigned   n_xfer  = 0;
  int unsigned   n_vcyc  = 0;
  int unsigned   n_ferr  = 0;
  int unsigned   n_ovr   = 0;
  int unsigned   n_perr  = 0;
  int unsigned   n_busy  = 0;
  logic [DW-1:0] last_xfer = '0;

  // Snapshots taken by the stimulus process
  int unsigned s_xfer, s_vcyc, s_ferr, s_ovr, s_perr, s_busy;

  always #5 clk = ~clk;

  inv_line_rx #(
    .OVERSAMPLE (OS),
    .DATA_W     (DW),
    .SYNC_STAGES(2),
    .LINE_INV   (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .line_i      (line_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .parity_err_o(parity_err_o)
  );

  always @(negedge clk) begin
    if (valid_o) n_vcyc++;
    if (valid_o && ready_i) begin
      n_xfer++;
      last_xfer = data_o;
    end
    if (frame_err_o)  n_ferr++;
    if (overrun_o)    n_ovr++;
    if (parity_err_o) n_perr++;
    if (busy_o)       n_busy++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_xfer = n_xfer; s_vcyc = n_vcyc; s_ferr = n_ferr;
    s_ovr  = n_ovr;  s_perr = n_perr; s_busy = n_busy;
  endtask

  // Line is inverted: logical bit b appears as ~b; glitch flips line cycle 8
  task automatic drive_bit(input logic b, input bit glitch);
    for (int c = 0; c < OS; c++) begin
      line_i = (glitch && c == 8) ? b : ~b;
      tick();
    end
  endtask

  task automatic idle(input int unsigned n);
    line_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop_b,
                            input bit glitch, input bit bad_par);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i], glitch);
`ifdef INV_LINE_RX_PARITY_EN
    drive_bit((^d) ^ bad_par, 1'b0);
`else
    if (bad_par) $display("note: parity not compiled in");
`endif
    drive_bit(stop_b, 1'b0);
  endtask

  initial begin
    rst     = 1'b1;
    line_i  = 1'b0;
    ready_i = 1'b1;
    repeat (3) tick();
    check("rst_data",  data_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_busy",  busy_o, 0);
    check("rst_ferr",  frame_err_o, 0);
    check("rst_ovr",   overrun_o, 0);
    check("rst_perr",  parity_err_o, 0);
    rst = 1'b0;
    idle(20);

    // Clean frame, consumer always ready
    snap();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    idle(4);
    check("a5_xfers", n_xfer - s_xfer, 1);
    check("a5_data",  last_xfer, 8'hA5);
    check("a5_vcyc",  n_vcyc - s_vcyc, 1);
    check("a5_ferr",  n_ferr - s_ferr, 0);
    check("a5_ovr",   n_ovr - s_ovr, 0);
    check("a5_perr",  n_perr - s_perr, 0);
    check("a5_busy_seen", (n_busy - s_busy) > 100, 1);
    check("a5_busy_end", busy_o, 0);

    // Runt start pulse
    snap();
    line_i = 1'b1;
    repeat (6) tick();
    idle(30);
    check("runt_xfers", n_xfer - s_xfer, 0);
    check("runt_ferr",  n_ferr - s_ferr, 0);
    check("runt_busy_seen", (n_busy - s_busy) > 0, 1);
    check("runt_busy_end", busy_o, 0);

    // Stop bit low, then a break, then idle and a good frame
    snap();
    send_frame(8'h77, 1'b0, 1'b0, 1'b0);
    line_i = 1'b1;
    repeat (30) tick();
    check("brk_ferr",  n_ferr - s_ferr, 1);
    check("brk_xfers", n_xfer - s_xfer, 0);
    idle(20);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    idle(4);
    check("3c_xfers", n_xfer - s_xfer, 1);
    check("3c_data",  last_xfer, 8'h3C);
    check("3c_ferr",  n_ferr - s_ferr, 1);

    // Overrun while the consumer stalls
    snap();
    ready_i = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    idle(4);
    check("ovr_valid1", valid_o, 1);
    check("ovr_data1",  data_o, 8'h11);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    idle(4);
    check("ovr_pulse", n_ovr - s_ovr, 1);
    check("ovr_hold",  data_o, 8'h11);
    check("ovr_valid2", valid_o, 1);
    check("ovr_noxfer", n_xfer - s_xfer, 0);
    ready_i = 1'b1;
    tick();
    tick();
    check("ovr_drain_valid", valid_o, 0);
    check("ovr_drain_xfers", n_xfer - s_xfer, 1);
    check("ovr_drain_data",  last_xfer, 8'h11);

    // One-cycle glitch in every data bit
    snap();
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    idle(4);
    check("glitch_xfers", n_xfer - s_xfer, 1);
    check("glitch_data",  last_xfer, 8'h5A);
    check("glitch_ferr",  n_ferr - s_ferr, 0);

    // Reset in the middle of 0xFF while the line is active
    snap();
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("mid_rst_data",  data_o, 0);
    check("mid_rst_busy",  busy_o, 0);
    for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    idle(20);
    check("mid_rst_xfers", n_xfer - s_xfer, 0);
    check("mid_rst_ferr",  n_ferr - s_ferr, 0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    idle(4);
    check("81_xfers", n_xfer - s_xfer, 1);
    check("81_data",  last_xfer, 8'h81);
    check("81_perr",  n_perr - s_perr, 0);

`ifdef INV_LINE_RX_PARITY_EN
    snap();
    send_frame(8'h81, 1'b1, 1'b0, 1'b1);
    idle(4);
    check("badpar_perr",  n_perr - s_perr, 1);
    check("badpar_xfers", n_xfer - s_xfer, 1);
    check("badpar_data",  last_xfer, 8'h81);
`endif

    check("perr_total_idle", parity_err_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
